sseg_scan_driver: RTL and testbench



---
 rtl/sseg_scan_driver.sv | 124 ++++++++++++
 tb/tb_sseg_scan_driver.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/sseg_scan_driver.sv
// Four-digit multiplexed seven-segment driver: latches all four patterns once per frame,
// scans one digit per slot with dead-time blanking at slot start and 16-step PWM dimming.
//
// state  | meaning
// S_IDLE | scan disabled; counters held at 0, all outputs inactive
// S_SCAN | slot/digit/pwm counters running, digits displayed in turn
module sseg_scan_driver #(
    parameter int CLK_DIV        = 50000,
    parameter int DEAD           = 500,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic       clk_clk,
    input  logic       reset_reset,
    input  logic       en,
    input  logic [3:0] bright,
    input  logic [7:0] sseg0,
    input  logic [7:0] sseg1,
    input  logic [7:0] sseg2,
    input  logic [7:0] sseg3,
    output logic [7:0] seg,
    output logic [3:0] an,
    output logic       frame_start
);

    localparam int              CW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0]   SLOT_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0]   DEAD_C    = CW'(DEAD);
    localparam logic [7:0]      SEG_OFF   = {8{SEG_ACTIVE_LOW}};
    localparam logic [3:0]      AN_OFF    = {4{AN_ACTIVE_LOW}};

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SCAN = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   slot_q, slot_d;
    logic [1:0]      digit_q, digit_d;
    logic [3:0]      pwm_q, pwm_d;
    logic [3:0][7:0] shadow_q, shadow_d;
    logic [7:0]      seg_q, seg_d;
    logic [3:0]      an_q, an_d;
    logic            fs_q, fs_d;
    logic            frame_latch;
    logic            lit;

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q  <= S_IDLE;
            slot_q   <= '0;
            digit_q  <= '0;
            pwm_q    <= '0;
            shadow_q <= '0;
            seg_q    <= SEG_OFF;
            an_q     <= AN_OFF;
            fs_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            slot_q   <= slot_d;
            digit_q  <= digit_d;
            pwm_q    <= pwm_d;
            shadow_q <= shadow_d;
            seg_q    <= seg_d;
            an_q     <= an_d;
            fs_q     <= fs_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        digit_d     = digit_q;
        pwm_d       = pwm_q;
        shadow_d    = shadow_q;
        frame_latch = 1'b0;
        lit         = 1'b0;

        case (state_q)
            S_IDLE: begin
                slot_d  = '0;
                digit_d = '0;
                pwm_d   = '0;
                if (en) begin
                    state_d     = S_SCAN;
                    frame_latch = 1'b1;
                end
            end
            S_SCAN: begin
                if (!en) begin
                    state_d = S_IDLE;
                    slot_d  = '0;
                    digit_d = '0;
                    pwm_d   = '0;
                end else begin
                    pwm_d = pwm_q + 4'd1;
                    lit   = (slot_q >= DEAD_C) && (pwm_q <= bright);
                    if (slot_q == SLOT_LAST) begin
                        slot_d      = '0;
                        digit_d     = digit_q + 2'd1;
                        // the edge entering digit 0 / slot 0 starts a new frame
                        frame_latch = (digit_q == 2'd3);
                    end else begin
                        slot_d = slot_q + CW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (frame_latch) begin
            shadow_d = {sseg3, sseg2, sseg1, sseg0};
        end

        fs_d  = frame_latch;
        an_d  = lit ? ((4'b0001 << digit_q) ^ AN_OFF) : AN_OFF;
        seg_d = lit ? (shadow_q[digit_q] ^ SEG_OFF) : SEG_OFF;
    end

    assign seg         = seg_q;
    assign an          = an_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Bench for sseg_scan_driver: two instances (active-low and active-high outputs) share stimulus;
// expected outputs are queued per cycle and checked by an independent monitor.
module tb_sseg_scan_driver;

    localparam int CD = 20;
    localparam int DT = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [3:0] bright = 4'd15;
    logic [7:0] s0 = 8'h00, s1 = 8'h00, s2 = 8'h00, s3 = 8'h00;
    logic [7:0] seg_lo, seg_hi;
    logic [3:0] an_lo, an_hi;
    logic       fs_lo, fs_hi;

    sseg_scan_driver #(.CLK_DIV(CD), .DEAD(DT), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) u_lo (
        .clk_clk(clk), .reset_reset(rst), .en(en), .bright(bright),
        .sseg0(s0), .sseg1(s1), .sseg2(s2), .sseg3(s3),
        .seg(seg_lo), .an(an_lo), .frame_start(fs_lo)
    );

    sseg_scan_driver #(.CLK_DIV(CD), .DEAD(DT), .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)) u_hi (
        .clk_clk(clk), .reset_reset(rst), .en(en), .bright(bright),
        .sseg0(s0), .sseg1(s1), .sseg2(s2), .sseg3(s3),
        .seg(seg_hi), .an(an_hi), .frame_start(fs_hi)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [3:0] an_lo;
        logic [7:0] seg_lo;
        logic [3:0] an_hi;
        logic [7:0] seg_hi;
        logic       fs;
    } exp_t;

    exp_t sb_q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // digit patterns packed {d3,d2,d1,d0}, bit set = segment lit
    localparam logic [31:0] P0 = 32'h4F5B063F;
    localparam logic [31:0] P1 = 32'h665B067F;

    // Expected outputs for a scan that left IDLE at edge number 'base'; j counts cycles after it.
    task automatic push_scan(input int base, input int j0, input int j1, input int b,
                             input logic [31:0] p0, input logic [31:0] p1);
        for (int j = j0; j <= j1; j++) begin
            exp_t       e;
            int         t;
            int         slot;
            int         dig;
            logic       lit;
            logic [7:0] pat;
            dig = 0;
            pat = 8'h00;
            lit = 1'b0;
            if (j > 0) begin
                t    = j - 1;
                slot = t % CD;
                dig  = (t / CD) % 4;
                lit  = (slot >= DT) && ((t % 16) <= b);
                pat  = (t / (4 * CD) == 0) ? p0[8*dig +: 8] : p1[8*dig +: 8];
            end
            e.cyc    = base + j;
            e.fs     = (j % (4 * CD) == 0);
            e.an_hi  = lit ? 4'(1 << dig) : 4'h0;
            e.seg_hi = lit ? pat : 8'h00;
            e.an_lo  = ~e.an_hi;
            e.seg_lo = ~e.seg_hi;
            sb_q.push_back(e);
        end
    endtask

    task automatic push_idle(input int c0, input int c1);
        for (int c = c0; c <= c1; c++) begin
            exp_t e;
            e.cyc    = c;
            e.fs     = 1'b0;
            e.an_lo  = 4'hF;
            e.seg_lo = 8'hFF;
            e.an_hi  = 4'h0;
            e.seg_hi = 8'h00;
            sb_q.push_back(e);
        end
    endtask

    task automatic go_neg(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
            e = sb_q.pop_front();
            n_cmp++;
            n_err++;
            $display("FAIL missed_check cyc=%0d expected entry never sampled (now cyc=%0d)", e.cyc, cyc);
        end
        if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
            e = sb_q.pop_front();
            n_cmp++;
            if (an_lo !== e.an_lo || seg_lo !== e.seg_lo || an_hi !== e.an_hi ||
                seg_hi !== e.seg_hi || fs_lo !== e.fs || fs_hi !== e.fs) begin
                n_err++;
                $display("FAIL scan_out cyc=%0d got an_lo=%h seg_lo=%h an_hi=%h seg_hi=%h fs=%b%b want an_lo=%h seg_lo=%h an_hi=%h seg_hi=%h fs=%b",
                         cyc, an_lo, seg_lo, an_hi, seg_hi, fs_lo, fs_hi,
                         e.an_lo, e.seg_lo, e.an_hi, e.seg_hi, e.fs);
            end
        end
    end

    always @(negedge clk) begin
        n_cmp++;
        if ($countones(an_hi) > 1 || $countones(~an_lo) > 1) begin
            n_err++;
            $display("FAIL one_hot cyc=%0d got an_lo=%b an_hi=%b want at most one active", cyc, an_lo, an_hi);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached at cyc=%0d", cyc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1);
    end

    initial begin
        int base;
        int base2;
        int base3;
        int base4;

        push_idle(2, 4);
        push_idle(5, 7);
        go_neg(4);
        rst = 1'b0;

        // full-brightness scan with a mid-frame pattern change while digit 2 shows
        go_neg(7);
        {s3, s2, s1, s0} = P0;
        bright = 4'd15;
        en = 1'b1;
        base = 8;
        push_scan(base, 0, 189, 15, P0, P1);
        go_neg(base + 50);
        s0 = 8'h7F;
        s3 = 8'h66;

        // drop enable mid-slot on digit 1, then resume
        go_neg(base + 189);
        en = 1'b0;
        push_idle(base + 190, base + 191);
        go_neg(base + 191);
        en = 1'b1;
        base2 = base + 192;
        push_scan(base2, 0, 39, 15, P1, P1);

        // reduced brightness, then back to full
        go_neg(base2 + 39);
        en = 1'b0;
        bright = 4'd3;
        push_idle(base2 + 40, base2 + 40);
        go_neg(base2 + 40);
        en = 1'b1;
        base3 = base2 + 41;
        push_scan(base3, 0, 169, 3, P1, P1);
        go_neg(base3 + 169);
        bright = 4'd15;
        push_scan(base3, 170, 199, 15, P1, P1);

        // asynchronous reset between edges while a digit is lit
        push_idle(base3 + 200, base3 + 203);
        go_neg(base3 + 199);
        @(posedge clk);
        #2 rst = 1'b1;
        go_neg(base3 + 203);
        rst = 1'b0;
        base4 = base3 + 204;
        push_scan(base4, 0, 99, 15, P1, P1);

        go_neg(base4 + 99);
        en = 1'b0;
        push_idle(base4 + 100, base4 + 102);
        go_neg(base4 + 104);

        while (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            n_cmp++;
            n_err++;
            $display("FAIL leftover_check cyc=%0d expected entry never sampled", e.cyc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
